// File: rtl/match_action_pkg.sv
// Shared types and the key hash for the exact-match flow table.
// The hash is used for both lookups and control-plane writes.
package match_action_pkg;

  localparam int KEY_WIDTH        = 128;
  localparam int DEF_ACTION_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CMP,
    DEL_CMP
  } flow_lkp_state_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [DEF_ACTION_WIDTH-1:0] action;
  } flow_entry_t;

  // XOR-fold the key into 16 bits, then keep only the low idx_w bits.
  function automatic logic [15:0] flow_hash(input logic [KEY_WIDTH-1:0] key, input int idx_w);
    logic [15:0] h;
    logic [15:0] mask;
    h    = '0;
    mask = '0;
    for (int i = 0; i < KEY_WIDTH / 16; i++) begin
      h ^= key[i*16 +: 16];
    end
    for (int i = 0; i < 16; i++) begin
      if (i < idx_w) mask[i] = 1'b1;
    end
    return h & mask;
  endfunction

endpackage

// File: rtl/flow_table_ram.sv
// Single-port synchronous-read RAM holding {key, action} per table slot.
// No reset: slot validity is tracked separately in flops by the lookup stage.
module flow_table_ram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 144,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/flow_table_lookup.sv
// Direct-mapped exact-match flow table: hash key -> read slot -> compare full key.
// Control-plane installs/deletes share the single RAM port and only run while idle.
module flow_table_lookup
  import match_action_pkg::*;
#(
  parameter  int TABLE_DEPTH  = 64,
  parameter  int ACTION_WIDTH = 16,
  localparam int IDX_W        = $clog2(TABLE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [127:0]            flow_key,
  input  logic                    valid_flow_key,
  input  logic                    cfg_wr_valid,
  output logic                    cfg_wr_ready,
  input  logic                    cfg_wr_del,
  input  logic [127:0]            cfg_wr_key,
  input  logic [ACTION_WIDTH-1:0] cfg_wr_action,
  output logic                    lookup_done,
  output logic                    lookup_hit,
  output logic [ACTION_WIDTH-1:0] lookup_action,
  output logic [IDX_W-1:0]        lookup_idx,
  output logic                    busy,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [15:0]             drop_count
);

  localparam int ENTRY_W = KEY_WIDTH + ACTION_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]    key;
    logic [ACTION_WIDTH-1:0] action;
  } entry_t;

  flow_lkp_state_t         state_q, state_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TABLE_DEPTH-1:0]  valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    hit_q, hit_d;
  logic [ACTION_WIDTH-1:0] action_q, action_d;
  logic [IDX_W-1:0]        res_idx_q, res_idx_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0]        lkp_idx;
  logic [IDX_W-1:0]        cfg_idx;
  logic                    ram_we;
  logic [IDX_W-1:0]        ram_addr;
  entry_t                  ram_wdata;
  entry_t                  ram_rdata;
  logic                    entry_match;

  assign lkp_idx      = IDX_W'(flow_hash(flow_key, IDX_W));
  assign cfg_idx      = IDX_W'(flow_hash(cfg_wr_key, IDX_W));
  assign cfg_wr_ready = (state_q == IDLE) && !valid_flow_key;
  assign ram_we       = cfg_wr_ready && cfg_wr_valid && !cfg_wr_del;
  // While idle the port serves config (install write or delete read); otherwise the latched index.
  assign ram_addr     = (state_q == IDLE) ? cfg_idx : idx_q;
  assign ram_wdata    = '{key: cfg_wr_key, action: cfg_wr_action};
  assign entry_match  = valid_q[idx_q] && (ram_rdata.key == key_q);

  flow_table_ram #(
    .DEPTH (TABLE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    action_d   = action_q;
    res_idx_d  = res_idx_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_cnt_q;

    // Upstream cannot be stalled, so a key arriving mid-operation is lost.
    if (valid_flow_key && (state_q != IDLE) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (valid_flow_key) begin
          key_d   = flow_key;
          idx_d   = lkp_idx;
          state_d = READ;
        end else if (cfg_wr_valid) begin
          if (cfg_wr_del) begin
            key_d   = cfg_wr_key;
            idx_d   = cfg_idx;
            state_d = DEL_CMP;
          end else begin
            valid_d[cfg_idx] = 1'b1;
          end
        end
      end
      READ: state_d = CMP;
      CMP: begin
        done_d    = 1'b1;
        hit_d     = entry_match;
        action_d  = entry_match ? ram_rdata.action : '0;
        res_idx_d = idx_q;
        if (entry_match) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end
        state_d = IDLE;
      end
      DEL_CMP: begin
        // Only drop the slot if it really holds the key being deleted.
        if (entry_match) valid_d[idx_q] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      idx_q      <= '0;
      valid_q    <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      action_q   <= '0;
      res_idx_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      action_q   <= action_d;
      res_idx_q  <= res_idx_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign lookup_done   = done_q;
  assign lookup_hit    = hit_q;
  assign lookup_action = action_q;
  assign lookup_idx    = res_idx_q;
  assign busy          = (state_q != IDLE);
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_flow_table_lookup.sv
// Scoreboard bench for flow_table_lookup: a plain array model of the direct-mapped
// table predicts each result; a negedge monitor checks every lookup_done against it.
module tb_flow_table_lookup;

  localparam int DEPTH = 64;
  localparam int AWID  = 16;

  logic         clk;
  logic         rst_n;
  logic [127:0] flow_key;
  logic         valid_flow_key;
  logic         cfg_wr_valid;
  logic         cfg_wr_ready;
  logic         cfg_wr_del;
  logic [127:0] cfg_wr_key;
  logic [15:0]  cfg_wr_action;
  logic         lookup_done;
  logic         lookup_hit;
  logic [15:0]  lookup_action;
  logic [5:0]   lookup_idx;
  logic         busy;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [15:0]  drop_count;

  flow_table_lookup #(
    .TABLE_DEPTH  (DEPTH),
    .ACTION_WIDTH (AWID)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flow_key       (flow_key),
    .valid_flow_key (valid_flow_key),
    .cfg_wr_valid   (cfg_wr_valid),
    .cfg_wr_ready   (cfg_wr_ready),
    .cfg_wr_del     (cfg_wr_del),
    .cfg_wr_key     (cfg_wr_key),
    .cfg_wr_action  (cfg_wr_action),
    .lookup_done    (lookup_done),
    .lookup_hit     (lookup_hit),
    .lookup_action  (lookup_action),
    .lookup_idx     (lookup_idx),
    .busy           (busy),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       hit;
    logic [15:0] action;
    logic [5:0] idx;
    int         due;
    int         hits;
    int         misses;
    int         drops;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  logic         m_valid [DEPTH];
  logic [127:0] m_key   [DEPTH];
  logic [15:0]  m_act   [DEPTH];
  int           m_hits, m_misses, m_drops;
  logic         last_hit;
  logic [15:0]  last_action;
  logic [5:0]   last_idx;

  logic [127:0] pool [16];

  function automatic logic [5:0] modelIdx(input logic [127:0] k);
    logic [15:0] h;
    h = 16'h0;
    for (int i = 0; i < 8; i++) h ^= k[i*16 +: 16];
    return h[5:0];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_hits      = 0;
    m_misses    = 0;
    m_drops     = 0;
    last_hit    = 1'b0;
    last_action = 16'h0;
    last_idx    = 6'h0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] key, input bit dbl);
    exp_t e;
    logic [5:0] ix;
    waitIdle();
    checkOutput("hold_hit", 128'(lookup_hit), 128'(last_hit));
    checkOutput("hold_action", 128'(lookup_action), 128'(last_action));
    checkOutput("hold_idx", 128'(lookup_idx), 128'(last_idx));
    ix       = modelIdx(key);
    e.hit    = m_valid[ix] && (m_key[ix] == key);
    e.action = e.hit ? m_act[ix] : 16'h0;
    e.idx    = ix;
    if (e.hit) m_hits++; else m_misses++;
    e.due          = cyc + 3;
    flow_key       = key;
    valid_flow_key = 1'b1;
    #1;
    if (dbl) checkOutput("ready_low_n", 128'(cfg_wr_ready), 128'(0));
    @(posedge clk); #1;
    if (dbl) begin
      m_drops++;
      flow_key = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput("ready_low_n1", 128'(cfg_wr_ready), 128'(0));
      @(posedge clk); #1;
      valid_flow_key = 1'b0;
      #1;
      checkOutput("ready_low_n2", 128'(cfg_wr_ready), 128'(0));
      checkOutput("busy_n2", 128'(busy), 128'(1));
    end else begin
      valid_flow_key = 1'b0;
    end
    e.hits   = m_hits;
    e.misses = m_misses;
    e.drops  = m_drops;
    sb.push_back(e);
    last_hit    = e.hit;
    last_action = e.action;
    last_idx    = e.idx;
  endtask

  task automatic cfgWrite(input logic [127:0] key, input logic [15:0] act, input bit del);
    logic [5:0] ix;
    waitIdle();
    cfg_wr_key    = key;
    cfg_wr_action = act;
    cfg_wr_del    = del;
    cfg_wr_valid  = 1'b1;
    #1;
    checkOutput("cfg_ready", 128'(cfg_wr_ready), 128'(1));
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
    ix = modelIdx(key);
    if (!del) begin
      m_valid[ix] = 1'b1;
      m_key[ix]   = key;
      m_act[ix]   = act;
    end else if (m_valid[ix] && m_key[ix] == key) begin
      m_valid[ix] = 1'b0;
    end
    if (del) begin
      #1;
      checkOutput("del_busy", 128'(busy), 128'(1));
      checkOutput("del_ready_low", 128'(cfg_wr_ready), 128'(0));
    end
  endtask

  always @(negedge clk) begin
    if (lookup_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: lookup_done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("latency", 128'(cyc), 128'(mon_e.due));
        checkOutput("hit", 128'(lookup_hit), 128'(mon_e.hit));
        checkOutput("action", 128'(lookup_action), 128'(mon_e.action));
        checkOutput("idx", 128'(lookup_idx), 128'(mon_e.idx));
        checkOutput("hit_count", 128'(hit_count), 128'(mon_e.hits));
        checkOutput("miss_count", 128'(miss_count), 128'(mon_e.misses));
        checkOutput("drop_count", 128'(drop_count), 128'(mon_e.drops));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] k;
    int           op;
    int unsigned  want;

    rst_n          = 1'b0;
    flow_key       = '0;
    valid_flow_key = 1'b0;
    cfg_wr_valid   = 1'b0;
    cfg_wr_del     = 1'b0;
    cfg_wr_key     = '0;
    cfg_wr_action  = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_done", 128'(lookup_done), 128'(0));
    checkOutput("rst_hit", 128'(lookup_hit), 128'(0));
    checkOutput("rst_action", 128'(lookup_action), 128'(0));
    checkOutput("rst_idx", 128'(lookup_idx), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_hits", 128'(hit_count), 128'(0));
    checkOutput("rst_misses", 128'(miss_count), 128'(0));
    checkOutput("rst_drops", 128'(drop_count), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty table miss, then install and hit.
    applyStimulus(128'h11, 1'b0);
    waitIdle();
    checkOutput("t1_hit", 128'(lookup_hit), 128'(0));
    checkOutput("t1_idx", 128'(lookup_idx), 128'(17));
    checkOutput("t1_miss_count", 128'(miss_count), 128'(1));
    cfgWrite(128'h11, 16'hBEEF, 1'b0);
    applyStimulus(128'h11, 1'b0);
    waitIdle();
    checkOutput("t2_hit", 128'(lookup_hit), 128'(1));
    checkOutput("t2_action", 128'(lookup_action), 128'hBEEF);
    checkOutput("t2_hit_count", 128'(hit_count), 128'(1));

    // Collision overwrite at index 17.
    cfgWrite(128'h11_0000, 16'h0A0A, 1'b0);
    applyStimulus(128'h11, 1'b0);
    waitIdle();
    checkOutput("t3_old_miss", 128'(lookup_hit), 128'(0));
    applyStimulus(128'h11_0000, 1'b0);
    waitIdle();
    checkOutput("t3_new_action", 128'(lookup_action), 128'h0A0A);

    // Back-to-back keys: second one dropped.
    applyStimulus(128'h11_0000, 1'b1);
    waitIdle();
    checkOutput("t4_drop_count", 128'(drop_count), 128'(1));

    // Deletes: matching, empty slot, non-matching key at occupied slot.
    cfgWrite(128'h11_0000, 16'h0, 1'b1);
    applyStimulus(128'h11_0000, 1'b0);
    waitIdle();
    checkOutput("t5_deleted_miss", 128'(lookup_hit), 128'(0));
    cfgWrite(128'h33, 16'h3333, 1'b0);
    cfgWrite(128'h22, 16'h0, 1'b1);
    applyStimulus(128'h33, 1'b0);
    cfgWrite(128'h11, 16'h1234, 1'b0);
    cfgWrite(128'h11_0000, 16'h0, 1'b1);
    applyStimulus(128'h11, 1'b0);
    waitIdle();
    checkOutput("t5_nomatch_kept", 128'(lookup_action), 128'h1234);

    // Reset while the lookup is in CMP: abandoned, table emptied.
    waitIdle();
    flow_key       = 128'h11;
    valid_flow_key = 1'b1;
    @(posedge clk); #1;
    valid_flow_key = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_busy_cmp", 128'(busy), 128'(1));
    rst_n = 1'b0;
    modelReset();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_done", 128'(lookup_done), 128'(0));
    checkOutput("t6_hits", 128'(hit_count), 128'(0));
    checkOutput("t6_misses", 128'(miss_count), 128'(0));
    checkOutput("t6_drops", 128'(drop_count), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(128'h11, 1'b0);
    waitIdle();
    checkOutput("t6_after_miss", 128'(lookup_hit), 128'(0));
    checkOutput("t6_after_miss_count", 128'(miss_count), 128'(1));

    // Random mix over a key pool squeezed into 8 slots to force collisions.
    for (int i = 0; i < 16; i++) begin
      k    = {$urandom, $urandom, $urandom, $urandom};
      want = $urandom_range(0, 7);
      k[5:0] = k[5:0] ^ modelIdx(k) ^ 6'(want);
      pool[i] = k;
    end
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 9));
      k  = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) k = {$urandom, $urandom, $urandom, $urandom};
      if (op <= 3) cfgWrite(k, 16'($urandom), 1'b0);
      else if (op == 4) cfgWrite(k, 16'h0, 1'b1);
      else if (op <= 8) applyStimulus(k, 1'b0);
      else applyStimulus(k, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    waitIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 128'(sb.size()), 128'(0));
    checkOutput("final_hits", 128'(hit_count), 128'(m_hits));
    checkOutput("final_misses", 128'(miss_count), 128'(m_misses));
    checkOutput("final_drops", 128'(drop_count), 128'(m_drops));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
